decoder_pipe: RTL and testbench

DECODER_PIPE -- requirements
Module: decoder_pipe

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_core.sv | 26 ++
 rtl/decoder_pipe.sv | 143 ++++++++++++++
 tb/tb_decoder_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder pipeline: FSM state encoding
// and the decode mode selectors.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FULL    = 2'd1,
        SW_OUT  = 2'd2,
        SW_WAIT = 2'd3
    } state_t;

    localparam logic ONE_HOT = 1'b0;
    localparam logic THERMO  = 1'b1;

endpackage

// File: rtl/decoder_core.sv
// Purely combinational code-to-word decoder: one-hot (single bit set) or
// thermometer (all bits up to and including the code set).
module decoder_core
    import decoder_pkg::*;
#(
    parameter int IN_W = 4
) (
    input  logic [IN_W-1:0]      code,
    input  logic                 thermo,
    output logic [2**IN_W-1:0]   word
);

    localparam int OUT_W = 2**IN_W;

    always_comb begin
        word = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (thermo == THERMO) begin
                word[i] = (IN_W'(i) <= code);
            end else begin
                word[i] = (IN_W'(i) == code);
            end
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// One-stage registered decoder with valid/ready handshake and an auto-sweep
// mode that walks a one-hot bit across the output with a programmable dwell.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int DWELL = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic                 in_thermo,
    input  logic                 sweep_start,
    input  logic                 sweep_stop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   out_data,
    output logic [IN_W-1:0]      out_code,
    output logic                 busy
);

    localparam int OUT_W = 2**IN_W;
    localparam int CNT_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    state_t             state;
    logic [IN_W-1:0]    step;
    logic [CNT_W-1:0]   dwell_cnt;
    logic               accept;
    logic               sweep_go;
    logic [IN_W-1:0]    sweep_code;
    logic [IN_W-1:0]    core_code;
    logic               core_thermo;
    logic [OUT_W-1:0]   core_word;

    assign in_ready = !sweep_start && ((state == IDLE) || ((state == FULL) && out_ready));
    assign accept   = in_valid && in_ready;
    assign sweep_go = (state == IDLE) && sweep_start && !sweep_stop;
    assign busy     = (state != IDLE);

    // The single decoder is shared: during a sweep it decodes the step that
    // is about to be presented, otherwise the incoming code.
    always_comb begin
        sweep_code = step;
        if (state == IDLE) begin
            sweep_code = '0;
        end else if (state == SW_OUT) begin
            sweep_code = step + IN_W'(1);
        end
        if (sweep_go || (state == SW_OUT) || (state == SW_WAIT)) begin
            core_code   = sweep_code;
            core_thermo = ONE_HOT;
        end else begin
            core_code   = in_code;
            core_thermo = in_thermo;
        end
    end

    decoder_core #(
        .IN_W   (IN_W)
    ) u_core (
        .code   (core_code),
        .thermo (core_thermo),
        .word   (core_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_code  <= '0;
            step      <= '0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sweep_go) begin
                        state     <= SW_OUT;
                        step      <= '0;
                        out_valid <= 1'b1;
                        out_data  <= core_word;
                        out_code  <= '0;
                    end else if (accept) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        out_data  <= enable ? core_word : '0;
                        out_code  <= in_code;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (accept) begin
                            out_valid <= 1'b1;
                            out_data  <= enable ? core_word : '0;
                            out_code  <= in_code;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                SW_OUT: begin
                    // A stop request only takes effect once the pending word is taken.
                    if (out_ready) begin
                        if (sweep_stop) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end else if (DWELL == 0) begin
                            step      <= sweep_code;
                            out_data  <= core_word;
                            out_code  <= sweep_code;
                        end else begin
                            step      <= sweep_code;
                            dwell_cnt <= CNT_W'(DWELL);
                            state     <= SW_WAIT;
                            out_valid <= 1'b0;
                        end
                    end
                end
                SW_WAIT: begin
                    if (sweep_stop) begin
                        state <= IDLE;
                    end else if (dwell_cnt <= CNT_W'(1)) begin
                        state     <= SW_OUT;
                        out_valid <= 1'b1;
                        out_data  <= core_word;
                        out_code  <= step;
                    end else begin
                        dwell_cnt <= dwell_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe (IN_W = 4, DWELL = 2): table-driven
// decodes through a scoreboard plus hand-written sweep/backpressure/reset sequences.
module tb_decoder_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        in_thermo;
    logic        sweep_start;
    logic        sweep_stop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_code;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  code;
        logic        thermo;
        logic        enable;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  code;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    decoder_pipe #(
        .IN_W        (4),
        .DWELL       (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .in_thermo   (in_thermo),
        .sweep_start (sweep_start),
        .sweep_stop  (sweep_stop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_code    (out_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code, input logic thermo, input logic en, input logic valid);
        in_code   = code;
        in_thermo = thermo;
        enable    = en;
        in_valid  = valid;
        #1;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake-completed output word is compared in order.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_word", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_data", {16'd0, out_data}, {16'd0, e.data});
                checkOutput("sb_code", {28'd0, out_code}, {28'd0, e.code});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        int last_cyc;
        bit hit;

        vecs[0] = '{4'h5, 1'b0, 1'b1, 16'h0020};
        vecs[1] = '{4'h3, 1'b1, 1'b1, 16'h000F};
        vecs[2] = '{4'hF, 1'b1, 1'b1, 16'hFFFF};
        vecs[3] = '{4'h0, 1'b1, 1'b1, 16'h0001};
        vecs[4] = '{4'h7, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{4'hA, 1'b0, 1'b1, 16'h0400};
        vecs[6] = '{4'hF, 1'b0, 1'b1, 16'h8000};
        vecs[7] = '{4'h0, 1'b0, 1'b1, 16'h0001};
        vecs[8] = '{4'h2, 1'b1, 1'b0, 16'h0000};

        reset       = 1'b1;
        sweep_start = 1'b0;
        sweep_stop  = 1'b0;
        out_ready   = 1'b1;
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
        step_cycle();
        step_cycle();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data",  {16'd0, out_data},  32'd0);
        checkOutput("rst_out_code",  {28'd0, out_code},  32'd0);
        checkOutput("rst_busy",      {31'd0, busy},      32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
        reset = 1'b0;
        step_cycle();

        $display("[TB] single one-hot decode");
        applyStimulus(4'h5, 1'b0, 1'b1, 1'b1);
        checkOutput("single_in_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back('{16'h0020, 4'h5});
        step_cycle();
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("single_valid_hi", {31'd0, out_valid}, 32'd1);
        step_cycle();
        checkOutput("single_valid_lo", {31'd0, out_valid}, 32'd0);
        checkOutput("single_busy_lo",  {31'd0, busy},      32'd0);

        $display("[TB] table vectors back-to-back");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].code, vecs[i].thermo, vecs[i].enable, 1'b1);
            checkOutput("tbl_in_ready", {31'd0, in_ready}, 32'd1);
            sb.push_back('{vecs[i].exp_data, vecs[i].code});
            step_cycle();
            checkOutput("tbl_out_valid", {31'd0, out_valid}, 32'd1);
        end
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
        step_cycle();
        checkOutput("tbl_drain_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(4'h1, 1'b0, 1'b1, 1'b1);
        checkOutput("bp_first_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back('{16'h0002, 4'h1});
        step_cycle();
        applyStimulus(4'h2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_in_ready_lo", {31'd0, in_ready},  32'd0);
            checkOutput("bp_hold_data",   {16'd0, out_data},  32'h0002);
            checkOutput("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
            step_cycle();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_hi", {31'd0, in_ready}, 32'd1);
        sb.push_back('{16'h0004, 4'h2});
        step_cycle();
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_next_data", {16'd0, out_data}, 32'h0004);
        step_cycle();

        $display("[TB] sweep with wrap");
        sweep_start = 1'b1;
        #1;
        checkOutput("sw_in_ready_lo", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 17; k++) begin
            exp_t e;
            e.code = 4'(k % 16);
            e.data = 16'd1 << (k % 16);
            sb.push_back(e);
        end
        seen = 0;
        last_cyc = 0;
        for (int c = 0; c < 120 && seen < 17; c++) begin
            step_cycle();
            sweep_start = 1'b0;
            if (out_valid) begin
                if (seen > 0) checkOutput("sw_gap", cyc - last_cyc, 32'd3);
                last_cyc = cyc;
                seen++;
            end
        end
        checkOutput("sw_word_count", seen, 32'd17);
        step_cycle();
        checkOutput("sw_wait_busy",  {31'd0, busy},      32'd1);
        checkOutput("sw_wait_valid", {31'd0, out_valid}, 32'd0);
        sweep_stop = 1'b1;
        step_cycle();
        sweep_stop = 1'b0;
        checkOutput("sw_stop_busy",  {31'd0, busy},      32'd0);
        checkOutput("sw_stop_valid", {31'd0, out_valid}, 32'd0);
        step_cycle();

        $display("[TB] simultaneous events");
        sweep_start = 1'b1;
        applyStimulus(4'h9, 1'b0, 1'b1, 1'b1);
        checkOutput("sim_in_ready_lo", {31'd0, in_ready}, 32'd0);
        sb.push_back('{16'h0001, 4'h0});
        step_cycle();
        sweep_start = 1'b0;
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("sim_sweep_busy",  {31'd0, busy},      32'd1);
        checkOutput("sim_sweep_valid", {31'd0, out_valid}, 32'd1);
        sweep_stop = 1'b1;
        step_cycle();
        sweep_stop = 1'b0;
        checkOutput("sim_stop_busy", {31'd0, busy}, 32'd0);

        sweep_start = 1'b1;
        sweep_stop  = 1'b1;
        #1;
        checkOutput("both_in_ready", {31'd0, in_ready}, 32'd0);
        step_cycle();
        sweep_start = 1'b0;
        sweep_stop  = 1'b0;
        checkOutput("both_busy",  {31'd0, busy},      32'd0);
        checkOutput("both_valid", {31'd0, out_valid}, 32'd0);
        step_cycle();

        $display("[TB] reset mid-sweep");
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.code = 4'(k);
            e.data = 16'd1 << k;
            sb.push_back(e);
        end
        sweep_start = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            step_cycle();
            sweep_start = 1'b0;
            if (out_valid && out_code == 4'h8) begin
                out_ready = 1'b0;
                hit = 1'b1;
            end
        end
        checkOutput("hold_reached", {31'd0, hit}, 32'd1);
        checkOutput("hold_data", {16'd0, out_data}, 32'h0100);
        sweep_stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step_cycle();
            checkOutput("stop_pending_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stop_pending_data",  {16'd0, out_data},  32'h0100);
        end
        sweep_stop = 1'b0;
        reset = 1'b1;
        step_cycle();
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_data",  {16'd0, out_data},  32'd0);
        checkOutput("mid_rst_busy",  {31'd0, busy},      32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            checkOutput("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        sweep_start = 1'b1;
        sb.push_back('{16'h0001, 4'h0});
        step_cycle();
        sweep_start = 1'b0;
        checkOutput("restart_data", {16'd0, out_data}, 32'h0001);
        sweep_stop = 1'b1;
        step_cycle();
        sweep_stop = 1'b0;
        checkOutput("restart_stop_busy", {31'd0, busy}, 32'd0);
        step_cycle();

        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
